// File: rtl/instruction_decode_if.sv
// rtl/instruction_decode_if.sv - fetch-to-decode and decode-to-execute signal bundle
interface instruction_decode_if;
    logic        run;
    logic [31:0] pc_in;
    logic [31:0] insn;
    logic        stall;
    logic        flush;
    logic        hazard_stall;
    logic        valid;
    logic [31:0] pc_out;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_auipc;
    logic        is_system;
    logic        illegal;

    modport slave (
        input  run, pc_in, insn, stall, flush,
        output hazard_stall, valid, pc_out, rd, rs1, rs2, funct3, imm, alu_op,
               alu_src_imm, reg_we, is_load, is_store, is_branch, is_jal,
               is_jalr, is_auipc, is_system, illegal
    );

    modport master (
        output run, pc_in, insn, stall, flush,
        input  hazard_stall, valid, pc_out, rd, rs1, rs2, funct3, imm, alu_op,
               alu_src_imm, reg_we, is_load, is_store, is_branch, is_jal,
               is_jalr, is_auipc, is_system, illegal
    );
endinterface

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage with registered micro-op and load-use detection
module instruction_decode #(
    parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_decode_if.slave   dif
);
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_MISC    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_auipc;
        logic        is_system;
        logic        illegal;
    } uop_t;

    localparam uop_t BUBBLE = '{pc: NOP_PC, default: '0};

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        uses_rs1, uses_rs2, we_raw, ill;
    uop_t        dec, uop_q;
    logic        hazard;

    assign insn   = dif.insn;
    assign opcode = insn[6:0];
    assign f3     = insn[14:12];
    assign f7     = insn[31:25];

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    always_comb begin
        dec      = BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        we_raw   = 1'b0;
        ill      = 1'b0;
        dec.valid  = 1'b1;
        dec.pc     = dif.pc_in;
        dec.funct3 = f3;
        // opcode includes insn[1:0], so compressed encodings fall into default
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                we_raw   = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = (f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    3'd1: dec.alu_op = ALU_SLL;
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: dec.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
                ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                uses_rs1        = 1'b1;
                we_raw          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                case (f3)
                    3'd0: dec.alu_op = ALU_ADD;
                    3'd1: dec.alu_op = ALU_SLL;
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: dec.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
                if (f3 == 3'd1)
                    ill = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    ill = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OPC_LOAD: begin
                uses_rs1        = 1'b1;
                we_raw          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.is_load     = 1'b1;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_s;
                dec.is_store    = 1'b1;
                ill = (f3 > 3'd2);
            end
            OPC_BRANCH: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JAL: begin
                we_raw     = 1'b1;
                dec.imm    = imm_j;
                dec.is_jal = 1'b1;
            end
            OPC_JALR: begin
                uses_rs1        = 1'b1;
                we_raw          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.is_jalr     = 1'b1;
                ill = (f3 != 3'd0);
            end
            OPC_LUI: begin
                we_raw          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASS;
            end
            OPC_AUIPC: begin
                we_raw          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
                dec.is_auipc    = 1'b1;
            end
            OPC_MISC: begin
            end
            OPC_SYSTEM: begin
                dec.is_system = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        dec.illegal = ill;
        dec.rs1     = uses_rs1 ? insn[19:15] : 5'd0;
        dec.rs2     = uses_rs2 ? insn[24:20] : 5'd0;
        dec.reg_we  = we_raw && !ill && (insn[11:7] != 5'd0);
        dec.rd      = dec.reg_we ? insn[11:7] : 5'd0;
        if (ill) begin
            dec.is_load  = 1'b0;
            dec.is_store = 1'b0;
        end
    end

    // rd != 0 is implied by is_load with reg_we set, but kept explicit for clarity
    assign hazard = uop_q.valid && uop_q.is_load && (uop_q.rd != 5'd0) &&
                    dif.run && !dif.flush && !dif.stall &&
                    ((uses_rs1 && insn[19:15] == uop_q.rd) ||
                     (uses_rs2 && insn[24:20] == uop_q.rd));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            uop_q <= BUBBLE;
        else if (dif.flush)
            uop_q <= BUBBLE;
        else if (dif.stall)
            uop_q <= uop_q;
        else if (hazard || !dif.run)
            uop_q <= BUBBLE;
        else
            uop_q <= dec;
    end

    assign dif.hazard_stall = hazard;
    assign dif.valid        = uop_q.valid;
    assign dif.pc_out       = uop_q.pc;
    assign dif.rd           = uop_q.rd;
    assign dif.rs1          = uop_q.rs1;
    assign dif.rs2          = uop_q.rs2;
    assign dif.funct3       = uop_q.funct3;
    assign dif.imm          = uop_q.imm;
    assign dif.alu_op       = uop_q.alu_op;
    assign dif.alu_src_imm  = uop_q.alu_src_imm;
    assign dif.reg_we       = uop_q.reg_we;
    assign dif.is_load      = uop_q.is_load;
    assign dif.is_store     = uop_q.is_store;
    assign dif.is_branch    = uop_q.is_branch;
    assign dif.is_jal       = uop_q.is_jal;
    assign dif.is_jalr      = uop_q.is_jalr;
    assign dif.is_auipc     = uop_q.is_auipc;
    assign dif.is_system    = uop_q.is_system;
    assign dif.illegal      = uop_q.illegal;
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- RV32I decode stage directly downstream of instruction fetch.
- Consumes the fetched pc/insn/run, produces a registered, fully decoded micro-op (register indices, sign-extended immediate, ALU op, control flags) for execute.
- Holds on stall, bubbles on flush, detects load-use hazards and requests an upstream stall.

Parameters:
NOP_PC, 32'h0000_0000, pc_out value driven while reset is asserted and in bubbles.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
run  in  1  fetch running; insn/pc_in are meaningful only when 1
pc_in  in  32  pc of insn
insn  in  32  instruction word
stall  in  1  downstream stall; hold all outputs
flush  in  1  branch/jump redirect; kill the incoming and current op
hazard_stall  out  1  combinational load-use stall request to fetch
valid  out  1  decoded op is live
pc_out  out  32  registered pc_in
rd, rs1, rs2  out  5 each  register indices (rd forced 0 when reg_we=0)
funct3  out  3  insn[14:12], for branch/load/store width
imm  out  32  sign-extended immediate
alu_op  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_IMM
alu_src_imm  out  1  ALU operand B is imm
reg_we, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_system, illegal  out  1 each  control flags

Behaviour:
- Reset (reset=0, async): every output 0; pc_out = NOP_PC. Outputs take effect immediately, not at the next clock edge.
- Latency: one clock. Decode is combinational from insn and is registered on the rising edge.
- Per-edge priority: flush > stall > hazard > normal.
  - flush=1: valid<=0, all flags<=0, rd<=0 (a bubble), regardless of stall.
  - stall=1: all outputs hold.
  - hazard_stall=1: bubble; upstream holds pc_in/insn, so the same insn is re-presented next cycle.
  - Otherwise, run=1 registers the decoded op with valid=1; run=0 produces a bubble.
- Immediate formats (all sign-extended from insn[31]):
  - I: OP-IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH (bit0=0)
  - U: LUI/AUIPC (low 12 bits = 0)
  - J: JAL
- Opcode mapping:
  - OP 0110011: alu_op from funct3/funct7; funct7 0x20 valid only for ADD→SUB and SRL→SRA; any other funct7 is illegal.
  - OP-IMM 0010011: alu_src_imm=1; SLLI/SRLI/SRAI check insn[31:25] the same way; ADDI never produces SUB.
  - LOAD 0000011: ADD, is_load. Legal funct3 ∈ {0,1,2,4,5}.
  - STORE 0100011: ADD, is_store, reg_we=0. Legal funct3 ∈ {0,1,2}.
  - BRANCH 1100011: is_branch, reg_we=0. Legal funct3 ∉ {2,3}.
  - JAL 1101111: is_jal, reg_we=1.
  - JALR 1100111: is_jalr, reg_we=1, ADD. Legal funct3=0.
  - LUI 0110111: PASS_IMM, reg_we=1.
  - AUIPC 0010111: is_auipc, ADD, reg_we=1.
  - MISC-MEM 0001111: valid NOP.
  - SYSTEM 1110011: is_system, reg_we=0.
  - Any other opcode, or insn[1:0]≠2'b11: illegal.
- illegal=1 forces reg_we, is_load and is_store to 0; valid stays 1 so the trap is visible downstream.
- reg_we is forced to 0 whenever rd=0.
- rs2 is driven only for OP/STORE/BRANCH, rs1 only for instructions that read it; unused index fields are 0.
- hazard_stall = valid & is_load & (rd≠0) & run & ~flush & ((uses_rs1 & insn[19:15]==rd) | (uses_rs2 & insn[24:20]==rd)), evaluated against the registered outputs. hazard_stall is also masked when stall=1.
- Reset deasserting mid-operation: resume with valid=0; the first op is registered on the first edge with run=1.

Test Plan:
- reset pulsed low mid-run with a live op → outputs 0 and pc_out=NOP_PC immediately, without waiting for a clock edge; after release with run=1, insn=0xFFF00093 (addi x1,x0,-1), pc_in=0x80000000 → next edge: valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, alu_op=ADD, alu_src_imm=1, reg_we=1, pc_out=0x80000000.
- insn=0xFE208EE3 (beq x1,x2,-4) → is_branch=1, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC, reg_we=0, rd=0.
- Load-use: lw x5,0(x2) (0x00012283), then add x6,x5,x1 (0x00128333):
  - cycle after lw: hazard_stall=1 and a bubble (valid=0);
  - following cycle: add issues with rs1=5, rs2=1, rd=6, hazard_stall=0;
  - repeat with add x6,x1,x0 → no hazard.
- stall=1 for 3 cycles with changing insn → outputs bit-identical to the pre-stall value; flush and stall asserted together → bubble, valid=0.
- Illegal inputs: insn=0x00000000 → valid=1, illegal=1, reg_we=0; insn=0x40001033 (funct7 0x20 with SLL) → illegal=1; run=0 → valid=0.
